// File: rtl/eret_controller_pkg.sv
// rtl/eret_controller_pkg.sv - shared coprocessor constants: state encodings and cause bit indices
package eret_controller_pkg;

    typedef enum logic [1:0] {
        ST_USER   = 2'b00,
        ST_KERNEL = 2'b01,
        ST_RETURN = 2'b10
    } state_e;

    localparam int CAUSE_W   = 2;
    localparam int CAUSE_OVF = 0;
    localparam int CAUSE_USR = 1;

    function automatic logic is_exception(input logic [CAUSE_W-1:0] c);
        return c[CAUSE_OVF] | c[CAUSE_USR];
    endfunction

endpackage

// File: rtl/eret_controller_if.sv
// rtl/eret_controller_if.sv - mode-logic / PC-unit signal bundle of the exception return controller
interface eret_controller_if
    import eret_controller_pkg::*;
#(
    parameter int PC_WIDTH = 16
);
    logic                enter;
    logic [CAUSE_W-1:0]  cause_in;
    logic [PC_WIDTH-1:0] pc_in;
    logic                eret;
    logic                pc_ack;
    logic                mode;
    logic                int_en;
    logic [PC_WIDTH-1:0] epc;
    logic [CAUSE_W-1:0]  cause;
    logic                restore_valid;
    logic [PC_WIDTH-1:0] restore_pc;
    logic                pending;

    modport master (
        output enter, cause_in, pc_in, eret, pc_ack,
        input  mode, int_en, epc, cause, restore_valid, restore_pc, pending
    );

    modport slave (
        input  enter, cause_in, pc_in, eret, pc_ack,
        output mode, int_en, epc, cause, restore_valid, restore_pc, pending
    );
endinterface

// File: rtl/eret_controller_exception_queue.sv
// rtl/eret_controller_exception_queue.sv - one-deep pending exception queue with cause merging
module exception_queue
    import eret_controller_pkg::*;
#(
    parameter int PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic [CAUSE_W-1:0]  cause_i,
    output logic                valid_o,
    output logic                eff_valid_o,
    output logic [PC_WIDTH-1:0] eff_pc_o,
    output logic [CAUSE_W-1:0]  eff_cause_o
);
    logic                valid_q, valid_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [CAUSE_W-1:0]  cause_q, cause_d;

    // Effective entry includes this cycle's push, so a same-cycle pop sees it.
    assign eff_valid_o = valid_q | push_i;
    assign eff_pc_o    = valid_q ? pc_q : pc_i;
    assign eff_cause_o = cause_q | (push_i ? cause_i : '0);
    assign valid_o     = valid_q;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        if (pop_i) begin
            valid_d = 1'b0;
            pc_d    = '0;
            cause_d = '0;
        end else if (push_i) begin
            valid_d = 1'b1;
            pc_d    = eff_pc_o;
            cause_d = eff_cause_o;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            cause_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end
endmodule

// File: rtl/eret_controller.sv
// rtl/eret_controller.sv - USER/KERNEL/RETURN exception entry and return sequencer
module eret_controller
    import eret_controller_pkg::*;
#(
    parameter int PC_WIDTH = 16
) (
    input  logic              CLK,
    input  logic              reset,
    eret_controller_if.slave  bus
);
    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic                int_en_q, int_en_d;
    logic [PC_WIDTH-1:0] epc_q, epc_d;
    logic [CAUSE_W-1:0]  cause_q, cause_d;
    logic                rv_q, rv_d;

    logic                exc, push, pop;
    logic                q_valid, q_eff_valid;
    logic [PC_WIDTH-1:0] q_eff_pc;
    logic [CAUSE_W-1:0]  q_eff_cause;

    assign exc  = bus.enter & is_exception(bus.cause_in);
    assign push = exc & (state_q != ST_USER);

    exception_queue #(.PC_WIDTH(PC_WIDTH)) u_queue (
        .clk         (CLK),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .pc_i        (bus.pc_in),
        .cause_i     (bus.cause_in),
        .valid_o     (q_valid),
        .eff_valid_o (q_eff_valid),
        .eff_pc_o    (q_eff_pc),
        .eff_cause_o (q_eff_cause)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        int_en_d = int_en_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        rv_d     = rv_q;
        pop      = 1'b0;
        case (state_q)
            ST_USER: begin
                if (exc) begin
                    state_d  = ST_KERNEL;
                    mode_d   = 1'b1;
                    int_en_d = 1'b0;
                    epc_d    = bus.pc_in;
                    cause_d  = bus.cause_in;
                end
            end
            ST_KERNEL: begin
                if (bus.eret) begin
                    state_d = ST_RETURN;
                    rv_d    = 1'b1;
                end
            end
            ST_RETURN: begin
                if (bus.pc_ack) begin
                    rv_d = 1'b0;
                    // A queued exception re-enters the kernel without dropping to user mode.
                    if (q_eff_valid) begin
                        pop     = 1'b1;
                        state_d = ST_KERNEL;
                        epc_d   = q_eff_pc;
                        cause_d = q_eff_cause;
                    end else begin
                        state_d  = ST_USER;
                        mode_d   = 1'b0;
                        int_en_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = ST_USER;
                mode_d   = 1'b0;
                int_en_d = 1'b1;
                rv_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= ST_USER;
            mode_q   <= 1'b0;
            int_en_q <= 1'b1;
            epc_q    <= '0;
            cause_q  <= '0;
            rv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            int_en_q <= int_en_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            rv_q     <= rv_d;
        end
    end

    assign bus.mode          = mode_q;
    assign bus.int_en        = int_en_q;
    assign bus.epc           = epc_q;
    assign bus.cause         = cause_q;
    assign bus.restore_valid = rv_q;
    assign bus.restore_pc    = epc_q;
    assign bus.pending       = q_valid;
endmodule
